// File: rtl/cpu_pkg.sv
// Types and widths shared between the writeback arbiter and its result FIFO.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_WB,
    SRC_FIFO
  } wb_src_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Small circular FIFO that holds divider results until the register file
// write port is free. Pointers wrap naturally because the depth is a power of two.
module wb_result_fifo
  import cpu_pkg::*;
#(
  parameter int  FIFO_DEPTH = 2,
  parameter type T          = wb_req_t
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push_i,
  input  T                            push_data_i,
  input  logic                        pop_i,
  output T                            head_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output logic                        full_o,
  output logic                        empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  T              mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is governed entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register file write port: arbitrates pipeline writeback against
// buffered divider results, tracks pending divide destinations and prevents FIFO starvation.
module regfile_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wb_we,
  input  logic [4:0]                  wb_rd,
  input  logic [31:0]                 wb_wd,
  input  logic                        div_issue,
  input  logic [4:0]                  div_issue_rd,
  input  logic                        div_valid,
  input  logic [4:0]                  div_rd,
  input  logic [31:0]                 div_wd,
  output logic                        div_ready,
  input  logic [4:0]                  dec_rs1,
  input  logic [4:0]                  dec_rs2,
  input  logic [4:0]                  dec_rd,
  input  logic                        dec_we,
  output logic                        stall_dec,
  output logic                        freeze_wb,
  output logic                        rf_we,
  output logic [4:0]                  rf_a3,
  output logic [31:0]                 rf_wd,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_req_t       push_req;
  wb_req_t       head;
  logic          fifo_full, fifo_empty;
  logic          push, pop;
  wb_src_e       src;
  logic [31:0]   pending_q, pending_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          freeze_q, freeze_d;

  assign div_ready = !reset && !fifo_full;
  assign push      = div_valid && div_ready && (div_rd != '0);
  assign push_req  = {1'b1, div_rd, div_wd};

  wb_result_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .T          (wb_req_t)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_req),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // A freeze cycle masks the pipeline so the FIFO head can drain.
  always_comb begin
    src = SRC_NONE;
    if (!reset) begin
      if (!freeze_q && wb_we && (wb_rd != '0)) src = SRC_WB;
      else if (!fifo_empty)                    src = SRC_FIFO;
    end
  end

  assign pop = (src == SRC_FIFO);

  always_comb begin
    rf_we = 1'b0;
    rf_a3 = '0;
    rf_wd = '0;
    case (src)
      SRC_WB: begin
        rf_we = 1'b1;
        rf_a3 = wb_rd;
        rf_wd = wb_wd;
      end
      SRC_FIFO: begin
        rf_we = head.we;
        rf_a3 = head.rd;
        rf_wd = head.wd;
      end
      default: ;
    endcase
  end

  // Set is applied after clear so a same-cycle reissue to the same rd stays pending.
  always_comb begin
    pending_d = pending_q;
    starve_d  = starve_q;
    freeze_d  = 1'b0;
    if (pop) pending_d[head.rd] = 1'b0;
    if (div_issue && (div_issue_rd != '0)) pending_d[div_issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
    if (pop) begin
      starve_d = '0;
    end else if ((src == SRC_WB) && !fifo_empty) begin
      if (starve_q == SW'(STARVE_LIMIT - 1)) begin
        starve_d = '0;
        freeze_d = 1'b1;
      end else begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      starve_q  <= '0;
      freeze_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      starve_q  <= starve_d;
      freeze_q  <= freeze_d;
    end
  end

  assign freeze_wb = freeze_q;
  assign stall_dec = pending_q[dec_rs1] | pending_q[dec_rs2] | (dec_we & pending_q[dec_rd]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: divider results are queued as expected writes and matched
// against every FIFO-sourced register file write; directed checks cover the rest.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_wd = '0;
  logic        div_issue = 1'b0;
  logic [4:0]  div_issue_rd = '0;
  logic        div_valid = 1'b0;
  logic [4:0]  div_rd = '0;
  logic [31:0] div_wd = '0;
  logic        div_ready;
  logic [4:0]  dec_rs1 = '0;
  logic [4:0]  dec_rs2 = '0;
  logic [4:0]  dec_rd = '0;
  logic        dec_we = 1'b0;
  logic        stall_dec;
  logic        freeze_wb;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [1:0]  fifo_count;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } exp_t;

  exp_t sb[$];
  logic expPipe = 1'b0;
  int   assertCount = 0;
  int   failCount = 0;

  regfile_wb_arbiter #(
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_wd        (wb_wd),
    .div_issue    (div_issue),
    .div_issue_rd (div_issue_rd),
    .div_valid    (div_valid),
    .div_rd       (div_rd),
    .div_wd       (div_wd),
    .div_ready    (div_ready),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rd       (dec_rd),
    .dec_we       (dec_we),
    .stall_dec    (stall_dec),
    .freeze_wb    (freeze_wb),
    .rf_we        (rf_we),
    .rf_a3        (rf_a3),
    .rf_wd        (rf_wd),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic iWbWe, input logic [4:0] iWbRd, input logic [31:0] iWbWd,
                               input logic iDivValid, input logic [4:0] iDivRd, input logic [31:0] iDivWd,
                               input logic iPipe);
    wb_we     = iWbWe;
    wb_rd     = iWbRd;
    wb_wd     = iWbWd;
    div_valid = iDivValid;
    div_rd    = iDivRd;
    div_wd    = iDivWd;
    expPipe   = iPipe;
  endtask

  task automatic pushExp(input logic [4:0] rd, input logic [31:0] wd);
    exp_t e;
    e.rd = rd;
    e.wd = wd;
    sb.push_back(e);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Every write-port cycle is checked: pipeline writes against the driven WB,
  // all other writes against the oldest outstanding divider result.
  always @(negedge clk) begin
    if (!reset) begin
      if (expPipe) begin
        checkOutput("pipe_we", 32'(rf_we), 32'd1);
        checkOutput("pipe_a3", 32'(rf_a3), 32'(wb_rd));
        checkOutput("pipe_wd", rf_wd, wb_wd);
      end else if (rf_we) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rf_we", 32'(rf_we), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("div_a3", 32'(rf_a3), 32'(e.rd));
          checkOutput("div_wd", rf_wd, e.wd);
        end
      end
    end
  end

  initial begin
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
    checkOutput("rst_div_ready", 32'(div_ready), 32'd0);
    checkOutput("rst_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_freeze", 32'(freeze_wb), 32'd0);
    checkOutput("rst_stall", 32'(stall_dec), 32'd0);
    nextCycle();
    reset = 1'b0;

    // Pipeline only
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("pipe_only_we", 32'(rf_we), 32'd1);
    checkOutput("pipe_only_count", 32'(fifo_count), 32'd0);
    nextCycle();

    // Divide RAW hazard
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    div_issue = 1'b1;
    div_issue_rd = 5'd7;
    nextCycle();
    div_issue = 1'b0;
    dec_rs1 = 5'd7;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h10, 1'b0);
    pushExp(5'd7, 32'h10);
    @(negedge clk);
    checkOutput("raw_stall", 32'(stall_dec), 32'd1);
    checkOutput("raw_div_ready", 32'(div_ready), 32'd1);
    checkOutput("raw_no_bypass", 32'(rf_we), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("raw_lat_we", 32'(rf_we), 32'd1);
    checkOutput("raw_stall_during_write", 32'(stall_dec), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("raw_stall_cleared", 32'(stall_dec), 32'd0);
    nextCycle();
    dec_rs1 = 5'd0;

    // Conflict: pipeline beats a queued result
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33, 1'b0);
    pushExp(5'd3, 32'h33);
    nextCycle();
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("conf_count_held", 32'(fifo_count), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("conf_drain_a3", 32'(rf_a3), 32'd3);
    nextCycle();
    @(negedge clk);
    checkOutput("conf_count_pop", 32'(fifo_count), 32'd0);
    nextCycle();

    // Starvation: four lost cycles force a one-cycle freeze
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0);
    pushExp(5'd9, 32'h99);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'(10 + i), 32'h1000 + 32'(i), 1'b0, 5'd0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("starve_nofreeze_%0d", i), 32'(freeze_wb), 32'd0);
      nextCycle();
    end
    applyStimulus(1'b1, 5'd20, 32'h2000, 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("starve_freeze", 32'(freeze_wb), 32'd1);
    checkOutput("starve_drain_a3", 32'(rf_a3), 32'd9);
    nextCycle();
    applyStimulus(1'b1, 5'd20, 32'h2000, 1'b0, 5'd0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("starve_no_b2b", 32'(freeze_wb), 32'd0);
    checkOutput("starve_count", 32'(fifo_count), 32'd0);
    nextCycle();

    // Full FIFO and backpressure
    applyStimulus(1'b1, 5'd11, 32'hA, 1'b1, 5'd12, 32'h120, 1'b1);
    pushExp(5'd12, 32'h120);
    @(negedge clk);
    checkOutput("full_ready0", 32'(div_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 5'd11, 32'hB, 1'b1, 5'd13, 32'h130, 1'b1);
    pushExp(5'd13, 32'h130);
    nextCycle();
    applyStimulus(1'b1, 5'd11, 32'hC, 1'b1, 5'd14, 32'h140, 1'b1);
    pushExp(5'd14, 32'h140);
    @(negedge clk);
    checkOutput("full_count", 32'(fifo_count), 32'd2);
    checkOutput("full_not_ready", 32'(div_ready), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'h140, 1'b0);
    @(negedge clk);
    checkOutput("full_pop_cycle_ready", 32'(div_ready), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("full_after_pop_ready", 32'(div_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("full_count_pushpop", 32'(fifo_count), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("full_count_empty", 32'(fifo_count), 32'd0);
    nextCycle();

    // Register-0 results and sources
    div_issue = 1'b1;
    div_issue_rd = 5'd0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hBAD, 1'b0);
    @(negedge clk);
    checkOutput("x0_div_ready", 32'(div_ready), 32'd1);
    nextCycle();
    div_issue = 1'b0;
    dec_we = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("x0_no_push", 32'(fifo_count), 32'd0);
    checkOutput("x0_no_write", 32'(rf_we), 32'd0);
    checkOutput("x0_no_stall", 32'(stall_dec), 32'd0);
    nextCycle();
    dec_we = 1'b0;

    // Reset with two entries queued and destinations pending
    div_issue = 1'b1;
    div_issue_rd = 5'd15;
    applyStimulus(1'b1, 5'd1, 32'h111, 1'b1, 5'd21, 32'h210, 1'b1);
    pushExp(5'd21, 32'h210);
    nextCycle();
    div_issue_rd = 5'd16;
    applyStimulus(1'b1, 5'd1, 32'h222, 1'b1, 5'd22, 32'h220, 1'b1);
    pushExp(5'd22, 32'h220);
    nextCycle();
    div_issue = 1'b0;
    dec_rs1 = 5'd15;
    applyStimulus(1'b1, 5'd1, 32'h333, 1'b0, 5'd0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("rstmid_count", 32'(fifo_count), 32'd2);
    checkOutput("rstmid_stall", 32'(stall_dec), 32'd1);
    nextCycle();
    reset = 1'b1;
    sb.delete();
    dec_rs1 = 5'd0;
    dec_rd = 5'd16;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("rstmid_rf_we", 32'(rf_we), 32'd0);
    checkOutput("rstmid_div_ready", 32'(div_ready), 32'd0);
    checkOutput("rstmid_dec_we_gate", 32'(stall_dec), 32'd0);
    nextCycle();
    reset = 1'b0;
    dec_rs1 = 5'd15;
    dec_rs2 = 5'd16;
    dec_we = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_count_after", 32'(fifo_count), 32'd0);
    checkOutput("rstmid_pending_after", 32'(stall_dec), 32'd0);
    checkOutput("rstmid_rf_we_after", 32'(rf_we), 32'd0);
    checkOutput("rstmid_freeze_after", 32'(freeze_wb), 32'd0);
    nextCycle();

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
